// File: rtl/input_conditioner_pkg.sv
// input_conditioner_pkg
// Shared types and default constants for the input conditioner and its
// reusable synchronizer.
//   cond_state_t        : debounce FSM state encoding
//   SYNC_STAGES_DEF     : default synchronizer depth
//   DEBOUNCE_CYCLES_DEF : default number of stable samples before a change
package input_conditioner_pkg;

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } cond_state_t;

  localparam int SYNC_STAGES_DEF     = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 16;

endpackage

// File: rtl/input_conditioner_if.sv
// input_conditioner_if
// Bundles the conditioner's data-path signals.
//   din_async  : raw asynchronous level (into the conditioner)
//   en         : synchronous enable (into the conditioner)
//   dout       : debounced registered level
//   rise_pulse : one-cycle pulse on dout 0->1
//   fall_pulse : one-cycle pulse on dout 1->0
//   busy       : debounce in progress
// master = the side producing din_async/en, slave = the conditioner.
interface input_conditioner_if;
  logic din_async;
  logic en;
  logic dout;
  logic rise_pulse;
  logic fall_pulse;
  logic busy;

  modport master (
    output din_async, en,
    input  dout, rise_pulse, fall_pulse, busy
  );

  modport slave (
    input  din_async, en,
    output dout, rise_pulse, fall_pulse, busy
  );
endinterface

// File: rtl/input_conditioner_sync_chain.sv
// sync_chain
// Multi-flop synchronizer bringing an asynchronous level into the clk domain.
//   clk : clock
//   rst : synchronous active-high reset, clears every stage
//   d   : asynchronous input
//   q   : synchronized output (last stage)
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // Shift the input through the chain every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {STAGES{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/input_conditioner.sv
// input_conditioner
// Synchronizes and debounces an external level, producing a clean registered
// level and single-cycle rise/fall pulses for downstream storage elements.
//   clk : clock
//   rst : synchronous active-high reset
//   bus : slave side of input_conditioner_if (din_async, en in;
//         dout, rise_pulse, fall_pulse, busy out)
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int SYNC_STAGES     = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input_conditioner_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  // With a single required sample the WAIT states are skipped entirely.
  localparam bit DIRECT = (DEBOUNCE_CYCLES == 1);

  logic             sync_s;
  cond_state_t      state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             dout_r;
  logic             rise_r;
  logic             fall_r;

  sync_chain #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.din_async),
    .q   (sync_s)
  );

  // Debounce FSM, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE_LO;
      cnt_r   <= CNT_ZERO;
      dout_r  <= 1'b0;
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else if (!bus.en) begin
      // Freeze: state, count and level hold; pulses are suppressed.
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
    end else begin
      rise_r  <= 1'b0;
      fall_r  <= 1'b0;
      case (state_r)
        IDLE_LO: begin
          if (sync_s) begin
            if (DIRECT) begin
              state_r <= IDLE_HI;
              cnt_r   <= CNT_ZERO;
              dout_r  <= 1'b1;
              rise_r  <= 1'b1;
            end else begin
              state_r <= WAIT_HI;
              cnt_r   <= CNT_ONE;
            end
          end
        end
        WAIT_HI: begin
          if (!sync_s) begin
            state_r <= IDLE_LO;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_HI;
            cnt_r   <= CNT_ZERO;
            dout_r  <= 1'b1;
            rise_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        IDLE_HI: begin
          if (!sync_s) begin
            if (DIRECT) begin
              state_r <= IDLE_LO;
              cnt_r   <= CNT_ZERO;
              dout_r  <= 1'b0;
              fall_r  <= 1'b1;
            end else begin
              state_r <= WAIT_LO;
              cnt_r   <= CNT_ONE;
            end
          end
        end
        WAIT_LO: begin
          if (sync_s) begin
            state_r <= IDLE_HI;
            cnt_r   <= CNT_ZERO;
          end else if (cnt_r == CNT_LAST) begin
            state_r <= IDLE_LO;
            cnt_r   <= CNT_ZERO;
            dout_r  <= 1'b0;
            fall_r  <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r <= IDLE_LO;
          cnt_r   <= CNT_ZERO;
          dout_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.dout       = dout_r;
  assign bus.rise_pulse = rise_r;
  assign bus.fall_pulse = fall_r;
  assign bus.busy       = (state_r == WAIT_HI) || (state_r == WAIT_LO);

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Front-end stage that takes an asynchronous, possibly bouncing external level, synchronizes it into the `clk` domain, debounces it and produces a clean registered level plus single-cycle edge pulses. It sits directly upstream of the D flip-flop and enable-latch storage elements: `dout` drives their `D` data input, and `rise_pulse`/`fall_pulse` drive their `enable` input.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flop count; legal range ≥ 2.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronized samples required before `dout` changes; legal range ≥ 1.
- `CNT_W`, default `$clog2(DEBOUNCE_CYCLES+1)`: debounce counter width; derived, never overridden.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on the rising edge of `clk`.
- `din_async` in 1: raw asynchronous input level.
- `en` in 1: synchronous enable; when low, the debounce FSM and counter hold.
- `dout` out 1: debounced level, registered.
- `rise_pulse` out 1: one-cycle high when `dout` goes 0→1.
- `fall_pulse` out 1: one-cycle high when `dout` goes 1→0.
- `busy` out 1: high while the FSM is in a WAIT state.

## Operation
- Synchronizer:
  - `SYNC_STAGES` flops in series; the last stage is `s`.
  - The chain runs every cycle regardless of `en`.
- FSM states: `IDLE_LO`, `WAIT_HI`, `IDLE_HI`, `WAIT_LO`.
- `IDLE_LO` (`dout`=0):
  - `s`=1 with `en`=1 → `WAIT_HI`, `cnt`=1.
  - If `DEBOUNCE_CYCLES`=1, go directly to `IDLE_HI` instead: `dout`←1, `rise_pulse` high.
- `WAIT_HI`:
  - `s`=0 → `IDLE_LO`, `cnt`=0, no pulse (glitch rejected).
  - `s`=1 and `cnt`=`DEBOUNCE_CYCLES`-1 → `IDLE_HI`, `dout`←1, `rise_pulse` high for that one cycle.
  - Otherwise `cnt`+1.
- `IDLE_HI` / `WAIT_LO`: mirror of the above with polarities swapped; completion drives `fall_pulse`.
- `en`=0:
  - State, `cnt` and `dout` hold.
  - `rise_pulse`/`fall_pulse` forced 0.
  - `busy` reflects the held state.
- Counter:
  - Never exceeds `DEBOUNCE_CYCLES`-1.
  - No wrap-around is possible.
  - Cleared on every entry to an IDLE state.
- `busy` = state is `WAIT_HI` or `WAIT_LO`; combinational from the state register.

## Timing
- Reset values:
  - sync chain all 0, state `IDLE_LO`, `cnt`=0.
  - `dout`=0, `rise_pulse`=0, `fall_pulse`=0, `busy`=0.
- Reset mid-operation: a reset asserted in a WAIT state aborts it. No pulse is issued and `dout` returns to 0 on that edge.
- Latency, with `en`=1 throughout and `din_async` changing before edge 1:
  - `s` changes at edge `SYNC_STAGES`.
  - `dout` and the pulse update at edge `SYNC_STAGES`+`DEBOUNCE_CYCLES`.
  - Defaults: edge 18.
- Pulse rules:
  - Each pulse is high for exactly one cycle and coincides with the first cycle of the new `dout` value.
  - `rise_pulse` and `fall_pulse` are never high together.
  - Minimum spacing between pulses is `DEBOUNCE_CYCLES` cycles.
- Glitches: any input pulse shorter than `DEBOUNCE_CYCLES` synchronized cycles produces no `dout` change.
- Simultaneous events:
  - `rst` has priority over `en`.
  - `en` falling on the completing edge suppresses the transition; the count holds at `DEBOUNCE_CYCLES`-1 and completes on the first edge with `en`=1 and `s` still differing.

## Structure
- Package `input_conditioner_pkg`: FSM state enum `cond_state_t` and constants `SYNC_STAGES_DEF`=2, `DEBOUNCE_CYCLES_DEF`=16.
- Sub-module `sync_chain`:
  - Parameter `STAGES`; ports `clk`, `rst`, `d`, `q`.
  - Reused by later blocks needing clock-domain entry.
- Top level holds the FSM, counter and output registers.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `din_async`=1 → all outputs 0, state `IDLE_LO`. Release reset → `rise_pulse` at edge 18 after release.
- Clean rise, defaults: `din_async` 0→1 before edge 1 → `dout`=1 and `rise_pulse`=1 at edge 18 only, `busy` high edges 3–17.
- Bounce: toggle `din_async` every 5 cycles for 40 cycles, then hold 1 → no pulse during bouncing. Exactly one `rise_pulse`, 18 edges after the final toggle.
- Enable freeze: assert `en`=0 for 10 cycles mid-WAIT at `cnt`=8 → `cnt` holds 8. `dout` changes 8 edges after `en` returns high.
- `DEBOUNCE_CYCLES`=1, `SYNC_STAGES`=3: input 1→0 from `IDLE_HI` → `fall_pulse` at edge 4, `busy` never asserted.
- Mid-wait reset: `rst` pulsed at `cnt`=10 in `WAIT_HI` → no pulse, `dout`=0, `cnt`=0 on the next edge.
